// File: rtl/moving_average_pkg.sv
// -----------------------------------------------------------------------------
// moving_average_pkg
// Shared constants and helpers for the parametrised boxcar moving-average
// filter.
//   ROUND_TRUNC / ROUND_HALF_UP : values for the ROUND parameter
//   WARMUP_ZERO / WARMUP_FULL   : values for the WARMUP_MODE parameter
//   acc_width(w, l)             : running-sum width for w-bit samples and
//                                 2^l taps (the sum of 2^l samples can never
//                                 overflow this width)
// -----------------------------------------------------------------------------
package moving_average_pkg;

   localparam int ROUND_TRUNC   = 0;   // floor(sum / N)
   localparam int ROUND_HALF_UP = 1;   // floor((sum + N/2) / N)

   localparam int WARMUP_ZERO   = 0;   // emit from the first sample, missing taps read as 0
   localparam int WARMUP_FULL   = 1;   // emit nothing until the window is full

   function automatic int acc_width(input int w, input int l);
      return w + l;
   endfunction

endpackage

// File: rtl/moving_average_ring.sv
// -----------------------------------------------------------------------------
// moving_average_ring
// N x WIDTH circular sample store (N = 2^LOG2_DEPTH). One asynchronous read
// and one synchronous write share the same index, so the oldest sample is read
// out in the same cycle it gets overwritten by the newest one. No reset on the
// storage: stale contents are masked upstream by the 'filled' flag, which lets
// the array map onto distributed RAM.
// Ports:
//   clk      clock
//   idx      read/write slot
//   wr_en    write wr_data into slot idx at the clock edge
//   wr_data  sample to store
//   rd_data  current contents of slot idx (combinational)
// -----------------------------------------------------------------------------
module moving_average_ring
   import moving_average_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int LOG2_DEPTH = 3
) (
   input  logic                  clk,
   input  logic [LOG2_DEPTH-1:0] idx,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   output logic [WIDTH-1:0]      rd_data
);

   localparam int DEPTH = 1 << LOG2_DEPTH;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx] <= wr_data;
      end
   end

   assign rd_data = mem[idx];

endmodule

// File: rtl/moving_average_param.sv
// -----------------------------------------------------------------------------
// moving_average_param
// Boxcar moving-average filter on a valid/ready sample stream. The output is
// the mean of the last 2^LOG2_DEPTH accepted samples, kept as a running sum
// (add newest, subtract the one leaving the window).
// Pipeline: input register -> running-sum update -> output register.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clear       synchronous flush of the filter history
//   in_data/in_vld/in_rdy     sample stream (transfer on in_vld & in_rdy)
//   out_data/out_vld/out_rdy  average stream (transfer on out_vld & out_rdy)
//   filled      window has held N samples since last reset/clear
//   count       samples in the window, saturating at N
// -----------------------------------------------------------------------------
module moving_average_param
   import moving_average_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int LOG2_DEPTH  = 3,
   parameter int SIGNED      = 1,
   parameter int ROUND       = ROUND_TRUNC,
   parameter int WARMUP_MODE = WARMUP_ZERO
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_vld,
   output logic                  in_rdy,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic                  filled,
   output logic [LOG2_DEPTH:0]   count
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int ACC_W = acc_width(WIDTH, LOG2_DEPTH);
   localparam logic [LOG2_DEPTH-1:0] LAST_IDX   = LOG2_DEPTH'(DEPTH - 1);
   localparam logic [LOG2_DEPTH:0]   FULL_COUNT = (LOG2_DEPTH + 1)'(DEPTH);
   localparam logic [ACC_W:0]        ROUND_ADD  =
      (ROUND == ROUND_HALF_UP) ? (ACC_W + 1)'(DEPTH / 2) : '0;

   // state
   logic                  in_v_reg,   in_v_next;
   logic [WIDTH-1:0]      in_d_reg,   in_d_next;
   logic                  out_v_reg,  out_v_next;
   logic [WIDTH-1:0]      out_d_reg,  out_d_next;
   logic [LOG2_DEPTH-1:0] idx_reg,    idx_next;
   logic [LOG2_DEPTH:0]   count_reg,  count_next;
   logic                  filled_reg, filled_next;
   logic [ACC_W-1:0]      acc_reg,    acc_next;

   // datapath
   logic [WIDTH-1:0]      ring_rd;
   logic [WIDTH-1:0]      old_sample;
   logic [ACC_W-1:0]      in_ext;
   logic [ACC_W-1:0]      old_ext;
   logic [ACC_W-1:0]      acc_sum;
   logic [ACC_W:0]        acc_wide;
   logic [ACC_W:0]        acc_rnd;
   logic [WIDTH-1:0]      avg;
   logic [LOG2_DEPTH:0]   unused_round_bits;

   // handshake
   logic                  suppress;
   logic                  adv;
   logic                  adv_go;

   moving_average_ring #(
      .WIDTH      (WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_ring (
      .clk     (clk),
      .idx     (idx_reg),
      .wr_en   (adv_go),
      .wr_data (in_d_reg),
      .rd_data (ring_rd)
   );

   // Until the window has wrapped once, the slot being overwritten holds
   // either nothing or a pre-clear sample, so it must contribute zero.
   assign old_sample = filled_reg ? ring_rd : '0;

   generate
      if (SIGNED != 0) begin : g_signed
         assign in_ext   = {{LOG2_DEPTH{in_d_reg[WIDTH-1]}}, in_d_reg};
         assign old_ext  = {{LOG2_DEPTH{old_sample[WIDTH-1]}}, old_sample};
         assign acc_wide = {acc_sum[ACC_W-1], acc_sum};
      end else begin : g_unsigned
         assign in_ext   = {{LOG2_DEPTH{1'b0}}, in_d_reg};
         assign old_ext  = {{LOG2_DEPTH{1'b0}}, old_sample};
         assign acc_wide = {1'b0, acc_sum};
      end
   endgenerate

   assign acc_sum = acc_reg - old_ext + in_ext;
   assign acc_rnd = acc_wide + ROUND_ADD;

   // Shift right by LOG2_DEPTH and keep WIDTH bits: the kept slice lies
   // entirely below the extension bits, so arithmetic vs logical shift makes
   // no difference to it.
   assign avg               = acc_rnd[LOG2_DEPTH +: WIDTH];
   assign unused_round_bits = {acc_rnd[ACC_W], acc_rnd[LOG2_DEPTH-1:0]};

   // In full-window warm-up mode the first N-1 samples only update the
   // history; they never need space in the output register.
   assign suppress = (WARMUP_MODE == WARMUP_FULL) && !filled_reg && (idx_reg != LAST_IDX);
   assign adv      = in_v_reg && (!out_v_reg || out_rdy || suppress);
   assign adv_go   = adv && !clear;
   assign in_rdy   = !clear && (!in_v_reg || adv);

   always_comb begin
      in_v_next   = in_v_reg;
      in_d_next   = in_d_reg;
      out_v_next  = out_v_reg;
      out_d_next  = out_d_reg;
      idx_next    = idx_reg;
      count_next  = count_reg;
      filled_next = filled_reg;
      acc_next    = acc_reg;

      // input register
      if (clear) begin
         in_v_next = 1'b0;
      end else if (in_vld && in_rdy) begin
         in_v_next = 1'b1;
         in_d_next = in_data;
      end else if (adv) begin
         in_v_next = 1'b0;
      end

      // history / running sum
      if (clear) begin
         idx_next    = '0;
         count_next  = '0;
         filled_next = 1'b0;
         acc_next    = '0;
      end else if (adv) begin
         idx_next    = idx_reg + 1'b1;
         acc_next    = acc_sum;
         filled_next = filled_reg || (idx_reg == LAST_IDX);
         if (count_reg != FULL_COUNT) begin
            count_next = count_reg + 1'b1;
         end
      end

      // output register; clear leaves a pending result in place
      if (out_v_reg && out_rdy) begin
         out_v_next = 1'b0;
      end
      if (adv_go && !suppress) begin
         out_v_next = 1'b1;
         out_d_next = avg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_v_reg   <= 1'b0;
         in_d_reg   <= '0;
         out_v_reg  <= 1'b0;
         out_d_reg  <= '0;
         idx_reg    <= '0;
         count_reg  <= '0;
         filled_reg <= 1'b0;
         acc_reg    <= '0;
      end else begin
         in_v_reg   <= in_v_next;
         in_d_reg   <= in_d_next;
         out_v_reg  <= out_v_next;
         out_d_reg  <= out_d_next;
         idx_reg    <= idx_next;
         count_reg  <= count_next;
         filled_reg <= filled_next;
         acc_reg    <= acc_next;
      end
   end

   assign out_data = out_d_reg;
   assign out_vld  = out_v_reg;
   assign filled   = filled_reg;
   assign count    = count_reg;

endmodule
